game_tick_scheduler: RTL and testbench

Sequences the snake game's movement timebase. It replaces a free-running divided clock with clock-enable pulses on the single system clock. A prescaler produces a base pulse every `PRESCALE` cycles, and a programmable beat counter turns base pulses into move requests. The game FSM acknowledges each request. The block sits between the system clock/reset and the snake update logic. It owns run/pause/game-over sequencing, speed-up on food, and the display blink rate.

---
 rtl/snake_pkg.sv | 13 +
 rtl/tick_prescaler.sv | 35 +++
 rtl/game_tick_scheduler.sv | 171 +++++++++++++++++
 tb/tb_game_tick_scheduler.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared definitions for the snake game: scheduler state encoding and the move-period width.
package snake_pkg;

   localparam int PERIOD_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_PAUSED = 2'd2,
      ST_OVER   = 2'd3
   } state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Enable-gated, clearable modulo-PRESCALE counter; o_base pulses on the last count while enabled.
module tick_prescaler #(
   parameter int PRESCALE = 100000
) (
   input  logic clk,
   input  logic reset,
   input  logic i_en,
   input  logic i_clr,
   output logic o_base
);

   localparam int              W    = $clog2(PRESCALE);
   localparam logic [W-1:0]    LAST = W'(PRESCALE - 1);

   logic [W-1:0] r_count;
   logic         w_atLast;

   assign w_atLast = (r_count == LAST);

   // Clear wins over enable so a restart always begins a fresh base interval.
   always_ff @(posedge clk) begin
      if (reset || i_clr) begin
         r_count <= '0;
      end else if (i_en) begin
         if (w_atLast) begin
            r_count <= '0;
         end else begin
            r_count <= r_count + 1'b1;
         end
      end
   end

   assign o_base = i_en && w_atLast;

endmodule

// File: rtl/game_tick_scheduler.sv
// Snake movement timebase: run/pause/over sequencing, beat counter, move handshake, speed-up and blink.
module game_tick_scheduler
   import snake_pkg::*;
#(
   parameter int PRESCALE     = 100000,
   parameter int START_PERIOD = 200,
   parameter int MIN_PERIOD   = 40,
   parameter int STEP         = 10,
   parameter int BLINK_HALF   = 250
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                pause,
   input  logic                game_over,
   input  logic                speed_up,
   input  logic                move_ack,
   output logic                move_req,
   output logic [PERIOD_W-1:0] period,
   output logic [1:0]          state,
   output logic                blink,
   output logic [7:0]          overrun_cnt
);

   localparam logic [PERIOD_W-1:0]        START_P    = PERIOD_W'(START_PERIOD);
   localparam logic [PERIOD_W-1:0]        MIN_P      = PERIOD_W'(MIN_PERIOD);
   localparam logic signed [PERIOD_W:0]   MIN_S      = (PERIOD_W + 1)'(MIN_PERIOD);
   localparam logic signed [PERIOD_W:0]   STEP_S     = (PERIOD_W + 1)'(STEP);
   localparam logic [7:0]                 BLINK_LAST = 8'(BLINK_HALF - 1);

   state_e                     r_state;
   state_e                     w_nextState;
   logic                       w_inRun;
   logic                       w_blinkActive;
   logic                       w_load;
   logic                       w_speedOk;
   logic                       w_leaving;

   logic                       w_base;
   logic                       w_blinkBase;
   logic                       w_tick;
   logic [PERIOD_W-1:0]        r_beat;
   logic [PERIOD_W-1:0]        r_period;
   logic signed [PERIOD_W:0]   w_diff;
   logic [PERIOD_W-1:0]        w_shrunk;
   logic [7:0]                 r_blinkCnt;
   logic                       r_blink;
   logic                       r_moveReq;
   logic [7:0]                 r_overrun;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // game_over outranks start, which outranks pause.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         ST_IDLE: begin
            if (start) w_nextState = ST_RUN;
         end
         ST_RUN: begin
            if (game_over)  w_nextState = ST_OVER;
            else if (pause) w_nextState = ST_PAUSED;
         end
         ST_PAUSED: begin
            if (game_over)  w_nextState = ST_OVER;
            else if (pause) w_nextState = ST_RUN;
         end
         ST_OVER: begin
            if (start) w_nextState = ST_RUN;
         end
         default: w_nextState = ST_IDLE;
      endcase
   end

   always_comb begin
      w_inRun       = (r_state == ST_RUN);
      w_blinkActive = (r_state == ST_PAUSED) || (r_state == ST_OVER);
      w_speedOk     = (r_state == ST_RUN) || (r_state == ST_PAUSED);
      w_load        = start && ((r_state == ST_IDLE) || (r_state == ST_OVER));
      w_leaving     = (w_nextState == ST_OVER) || (w_nextState == ST_IDLE);
   end

   // The beat prescaler only runs in RUN, so pausing freezes its phase exactly.
   tick_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_beatPrescaler (
      .clk    (clk),
      .reset  (reset),
      .i_en   (w_inRun),
      .i_clr  (w_load || (r_state == ST_IDLE)),
      .o_base (w_base)
   );

   tick_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_blinkPrescaler (
      .clk    (clk),
      .reset  (reset),
      .i_en   (w_blinkActive),
      .i_clr  (!w_blinkActive),
      .o_base (w_blinkBase)
   );

   assign w_tick = w_inRun && w_base &&
                   ({1'b0, r_beat} >= ({1'b0, r_period} - 9'd1));

   always_ff @(posedge clk) begin
      if (reset || w_load || w_tick) begin
         r_beat <= '0;
      end else if (w_inRun && w_base) begin
         r_beat <= r_beat + 1'b1;
      end
   end

   assign w_diff   = $signed({1'b0, r_period}) - STEP_S;
   assign w_shrunk = (w_diff < MIN_S) ? MIN_P : w_diff[PERIOD_W-1:0];

   always_ff @(posedge clk) begin
      if (reset || w_load) begin
         r_period <= START_P;
      end else if (speed_up && w_speedOk) begin
         r_period <= w_shrunk;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || (w_nextState == ST_IDLE) || (w_nextState == ST_RUN)) begin
         r_blinkCnt <= '0;
         r_blink    <= 1'b0;
      end else if (w_blinkBase) begin
         if (r_blinkCnt >= BLINK_LAST) begin
            r_blinkCnt <= '0;
            r_blink    <= !r_blink;
         end else begin
            r_blinkCnt <= r_blinkCnt + 1'b1;
         end
      end
   end

   // A tick arriving with an ack replaces the consumed move, so tick has priority over ack.
   always_ff @(posedge clk) begin
      if (reset || w_leaving) begin
         r_moveReq <= 1'b0;
      end else if (w_tick) begin
         r_moveReq <= 1'b1;
      end else if (move_ack) begin
         r_moveReq <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || w_load) begin
         r_overrun <= '0;
      end else if (w_tick && r_moveReq && !move_ack && (r_overrun != 8'hFF)) begin
         r_overrun <= r_overrun + 1'b1;
      end
   end

   assign move_req    = r_moveReq;
   assign period      = r_period;
   assign state       = r_state;
   assign blink       = r_blink;
   assign overrun_cnt = r_overrun;

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Randomized and directed bench for game_tick_scheduler against a cycle-level behavioural model.
module tb_game_tick_scheduler;

   localparam int P    = 4;
   localparam int SP   = 5;
   localparam int MINP = 2;
   localparam int STP  = 2;
   localparam int BH   = 2;

   localparam int S_IDLE   = 0;
   localparam int S_RUN    = 1;
   localparam int S_PAUSED = 2;
   localparam int S_OVER   = 3;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       pause;
   logic       game_over;
   logic       speed_up;
   logic       move_ack;
   logic       move_req;
   logic [7:0] period;
   logic [1:0] state;
   logic       blink;
   logic [7:0] overrun_cnt;

   int nCompared   = 0;
   int nMismatched = 0;

   int mState;
   bit mReq;
   int mPeriod;
   bit mBlink;
   int mOvr;
   int mRunCyc;
   int mBeats;
   int mBlinkCyc;

   always #5 clk = ~clk;

   game_tick_scheduler #(
      .PRESCALE     (P),
      .START_PERIOD (SP),
      .MIN_PERIOD   (MINP),
      .STEP         (STP),
      .BLINK_HALF   (BH)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .pause       (pause),
      .game_over   (game_over),
      .speed_up    (speed_up),
      .move_ack    (move_ack),
      .move_req    (move_req),
      .period      (period),
      .state       (state),
      .blink       (blink),
      .overrun_cnt (overrun_cnt)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input int expected);
      nCompared++;
      if (observed !== expected) begin
         nMismatched++;
         $display("[TB] FAIL %s: observed %0d, expected %0d at %0t", tag, observed, expected, $time);
      end
   endtask

   // True when the model predicts a move tick at the coming edge.
   function automatic bit modelWillTick();
      return (mState == S_RUN) && ((mRunCyc % P) == P - 1) && (mBeats >= mPeriod - 1);
   endfunction

   // Model: count RUN cycles for base pulses, count bases for moves, count blink-active cycles for blink.
   task automatic modelStep(input bit r, input bit s, input bit p, input bit g, input bit su, input bit a);
      int nxt;
      bit tick;
      bit base;
      if (r) begin
         mState = S_IDLE; mReq = 0; mPeriod = SP; mBlink = 0; mOvr = 0;
         mRunCyc = 0; mBeats = 0; mBlinkCyc = 0;
         return;
      end
      nxt = mState;
      case (mState)
         S_IDLE:   if (s) nxt = S_RUN;
         S_RUN:    if (g) nxt = S_OVER; else if (p) nxt = S_PAUSED;
         S_PAUSED: if (g) nxt = S_OVER; else if (p) nxt = S_RUN;
         default:  if (s) nxt = S_RUN;
      endcase
      tick = 0;
      if (mState == S_RUN) begin
         base = ((mRunCyc % P) == P - 1);
         mRunCyc++;
         if (base) begin
            if (mBeats >= mPeriod - 1) begin
               tick = 1;
               mBeats = 0;
            end else begin
               mBeats++;
            end
         end
      end
      if (mState == S_PAUSED || mState == S_OVER) begin
         if ((mBlinkCyc % (P * BH)) == P * BH - 1) mBlink = !mBlink;
         mBlinkCyc++;
      end else begin
         mBlinkCyc = 0;
      end
      if (nxt == S_IDLE || nxt == S_RUN) mBlink = 0;
      if (tick && mReq && !a && mOvr < 255) mOvr++;
      if (nxt == S_OVER || nxt == S_IDLE) mReq = 0;
      else if (tick) mReq = 1;
      else if (a) mReq = 0;
      if (su && (mState == S_RUN || mState == S_PAUSED))
         mPeriod = (mPeriod - STP < MINP) ? MINP : mPeriod - STP;
      if (s && (mState == S_IDLE || mState == S_OVER)) begin
         mPeriod = SP; mRunCyc = 0; mBeats = 0; mOvr = 0;
      end
      mState = nxt;
   endtask

   task automatic applyStimulus(input bit r, input bit s, input bit p, input bit g, input bit su, input bit a);
      reset = r; start = s; pause = p; game_over = g; speed_up = su; move_ack = a;
      @(posedge clk);
      modelStep(r, s, p, g, su, a);
      #1;
      checkOutput("state",    32'(state),       mState);
      checkOutput("move_req", 32'(move_req),    int'(mReq));
      checkOutput("period",   32'(period),      mPeriod);
      checkOutput("blink",    32'(blink),       int'(mBlink));
      checkOutput("overrun",  32'(overrun_cnt), mOvr);
   endtask

   // Counts edges until move_req is seen high; -1 if the bound expires.
   task automatic measureRise(input int bound, output int cnt);
      cnt = -1;
      for (int i = 1; i <= bound; i++) begin
         applyStimulus(0, 0, 0, 0, 0, 0);
         if (move_req === 1'b1) begin
            cnt = i;
            break;
         end
      end
   endtask

   initial begin
      int cnt;
      reset = 1'b1; start = 1'b0; pause = 1'b0; game_over = 1'b0; speed_up = 1'b0; move_ack = 1'b0;
      mState = S_IDLE; mReq = 0; mPeriod = SP; mBlink = 0; mOvr = 0;
      mRunCyc = 0; mBeats = 0; mBlinkCyc = 0;

      applyStimulus(1, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0);
      checkOutput("rstState",  32'(state),       0);
      checkOutput("rstReq",    32'(move_req),    0);
      checkOutput("rstPeriod", 32'(period),      SP);
      checkOutput("rstBlink",  32'(blink),       0);
      checkOutput("rstOvr",    32'(overrun_cnt), 0);
      applyStimulus(0, 0, 0, 0, 0, 0);

      applyStimulus(0, 1, 0, 0, 0, 0);
      measureRise(40, cnt);
      checkOutput("firstRise", 32'(cnt), SP * P);
      applyStimulus(0, 0, 0, 0, 0, 1);
      measureRise(40, cnt);
      checkOutput("secondRise", 32'(cnt + 1), SP * P);
      checkOutput("ovrZero", 32'(overrun_cnt), 0);

      for (int i = 0; i < 80; i++) applyStimulus(0, 0, 0, 0, 0, modelWillTick());
      checkOutput("tickAckReq", 32'(move_req), 1);
      checkOutput("tickAckOvr", 32'(overrun_cnt), 0);

      for (int i = 0; i < 5200; i++) applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("ovrSat", 32'(overrun_cnt), 255);
      checkOutput("reqHeld", 32'(move_req), 1);

      for (int i = 0; i < 10 && mReq; i++) applyStimulus(0, 0, 0, 0, 0, !modelWillTick());
      measureRise(40, cnt);
      checkOutput("syncRise", 32'(cnt > 0), 1);
      applyStimulus(0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 1, 0, 0, 0);
      for (int i = 1; i <= 36; i++) begin
         applyStimulus(0, 0, 0, 0, 0, 0);
         if (i == 8)  checkOutput("blinkP8",  32'(blink), 1);
         if (i == 16) checkOutput("blinkP16", 32'(blink), 0);
      end
      applyStimulus(0, 0, 1, 0, 0, 0);
      measureRise(40, cnt);
      checkOutput("pauseRise", 32'(cnt), 12);
      checkOutput("blinkResume", 32'(blink), 0);

      applyStimulus(0, 0, 0, 0, 1, 1);
      checkOutput("speed1", 32'(period), 3);
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 1, 0);
      checkOutput("speed2", 32'(period), 2);
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 1, 0);
      checkOutput("speed3", 32'(period), MINP);
      for (int i = 0; i < 20; i++) applyStimulus(0, 0, 0, 0, 0, mReq);

      applyStimulus(0, 0, 1, 1, 0, 0);
      checkOutput("goPauseState", 32'(state), S_OVER);
      checkOutput("goPauseReq",   32'(move_req), 0);
      for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 0, 0, 0, 0);
      checkOutput("restartPeriod", 32'(period), SP);
      checkOutput("restartOvr",    32'(overrun_cnt), 0);
      measureRise(40, cnt);
      checkOutput("restartRise", 32'(cnt), SP * P);

      for (int i = 0; i < 7; i++) applyStimulus(0, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0);
      checkOutput("midRstState",  32'(state),       0);
      checkOutput("midRstReq",    32'(move_req),    0);
      checkOutput("midRstPeriod", 32'(period),      SP);
      checkOutput("midRstBlink",  32'(blink),       0);
      checkOutput("midRstOvr",    32'(overrun_cnt), 0);

      for (int i = 0; i < 3000; i++) begin
         applyStimulus($urandom_range(999) == 0,
                       $urandom_range(99) < 3,
                       $urandom_range(99) < 2,
                       $urandom_range(99) < 1,
                       $urandom_range(99) < 4,
                       $urandom_range(99) < 30);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
